// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM pipeline stage: reset polarity constants,
// bus widths, memory op encodings, FSM state encoding and small decode helpers.
// Optional feature macro used by the stage: MEM_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package mem_access_pkg;

  // Reset is active-low.
  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 4;
  localparam int STRB_W     = 4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Memory access type carried from EX/MEM. Codes 9..15 are treated as NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    logic r;
    case (op)
      OP_SB, OP_SH, OP_SW: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte lane of the access. Halves only look at addr[1] and words ignore the
  // low bits, so misaligned addresses degrade to the enclosing aligned unit.
  function automatic logic [1:0] lane_offset(input logic [3:0] op, input logic [1:0] lo);
    logic [1:0] r;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = {lo[1], 1'b0};
      OP_LW, OP_SW:         r = 2'b00;
      default:              r = lo;
    endcase
    return r;
  endfunction

  // True when the access is not naturally aligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = lo[0];
      OP_LW, OP_SW:         r = |lo;
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational lane logic for the MEM stage: store strobe generation, store
// data lane replication and load byte/half selection with sign/zero extension.
// Ports:
//   op        in  4   memory op code
//   addr_lo   in  2   effective address bits [1:0]
//   sdata     in  32  raw store data
//   rdata     in  32  word returned by the data SRAM (held copy)
//   strb      out 4   byte write strobes for stores (0 otherwise)
//   wdata     out 32  store data replicated across lanes
//   load_data out 32  extended load result
// -----------------------------------------------------------------------------
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [1:0]  off_s;
  logic [31:0] shifted_s;

  // Lane offset and the read word shifted so the selected lane sits at bit 0.
  always_comb begin
    off_s     = lane_offset(op, addr_lo);
    shifted_s = rdata >> {off_s, 3'b000};
  end

  // Load extension; words use offset 0 so the shifted word is the raw word.
  always_comb begin
    case (op)
      OP_LB:   load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      OP_LBU:  load_data = {24'h00_0000, shifted_s[7:0]};
      OP_LH:   load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      OP_LHU:  load_data = {16'h0000, shifted_s[15:0]};
      OP_LW:   load_data = shifted_s;
      default: load_data = ZERO_WORD;
    endcase
  end

  // Store strobes and lane-replicated store data.
  always_comb begin
    case (op)
      OP_SB: begin
        strb  = 4'b0001 << off_s;
        wdata = {4{sdata[7:0]}};
      end
      OP_SH: begin
        strb  = 4'b0011 << off_s;
        wdata = {2{sdata[15:0]}};
      end
      OP_SW: begin
        strb  = 4'b1111;
        wdata = sdata;
      end
      default: begin
        strb  = 4'b0000;
        wdata = ZERO_WORD;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// MEM pipeline stage. NOPs flow straight through to the MEM/WB register; loads
// and stores run a data-SRAM handshake (IDLE -> REQ -> WAIT -> DONE) while the
// front of the pipeline is frozen through stall_req.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses (no SRAM request, ale pulse with the faulting address).
// Ports:
//   clk, rst                     clock, async active-low reset
//   mem_waddr/mem_wdata/mem_write destination reg, ALU result, write enable
//   mem_op/mem_addr/mem_sdata    access type, effective address, store data
//   wb_waddr/wb_wdata/wb_write   result toward MEM/WB
//   dreq/dwr/dwstrb/daddr/dwdata data-SRAM request (registered)
//   daddr_ok/ddata_ok/drdata     data-SRAM accept, completion, read data
//   stall_req                    freeze IF..EX/MEM
//   ale/ale_addr                 alignment exception flag and address
// -----------------------------------------------------------------------------
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_write,
  output logic        dreq,
  output logic        dwr,
  output logic [3:0]  dwstrb,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic        daddr_ok,
  input  logic        ddata_ok,
  input  logic [31:0] drdata,
  output logic        stall_req,
  output logic        ale,
  output logic [31:0] ale_addr
);

  state_e      state_r;
  logic [31:0] rdata_r;
  logic        dreq_r;
  logic        dwr_r;
  logic [3:0]  dwstrb_r;
  logic [31:0] daddr_r;
  logic [31:0] dwdata_r;

  logic        op_load_s;
  logic        op_store_s;
  logic        op_mem_s;
  logic        fault_s;
  logic        start_s;
  logic [3:0]  strb_s;
  logic [31:0] lanes_s;
  logic [31:0] load_data_s;

  // Op decode and alignment fault detection.
  always_comb begin
    op_load_s  = is_load(mem_op);
    op_store_s = is_store(mem_op);
    op_mem_s   = op_load_s | op_store_s;
`ifdef MEM_ALIGN_CHECK_EN
    fault_s    = op_mem_s & misaligned(mem_op, mem_addr[1:0]);
`else
    fault_s    = 1'b0;
`endif
    start_s    = (state_r == ST_IDLE) && op_mem_s && !fault_s;
  end

  // The held read word feeds load extension, so DONE is immune to drdata changes.
  mem_align u_align (
    .op        (mem_op),
    .addr_lo   (mem_addr[1:0]),
    .sdata     (mem_sdata),
    .rdata     (rdata_r),
    .strb      (strb_s),
    .wdata     (lanes_s),
    .load_data (load_data_s)
  );

  // Access FSM with registered SRAM request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_r  <= ST_IDLE;
      rdata_r  <= ZERO_WORD;
      dreq_r   <= 1'b0;
      dwr_r    <= 1'b0;
      dwstrb_r <= 4'b0000;
      daddr_r  <= ZERO_WORD;
      dwdata_r <= ZERO_WORD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r  <= ST_REQ;
            dreq_r   <= 1'b1;
            dwr_r    <= op_store_s;
            dwstrb_r <= op_store_s ? strb_s : 4'b0000;
            daddr_r  <= {mem_addr[31:2], 2'b00};
            dwdata_r <= op_store_s ? lanes_s : ZERO_WORD;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Request is withdrawn the cycle after the address is accepted.
          if (daddr_ok) begin
            state_r  <= ST_WAIT;
            dreq_r   <= 1'b0;
            dwr_r    <= 1'b0;
            dwstrb_r <= 4'b0000;
          end else begin
            state_r  <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (ddata_ok) begin
            state_r <= ST_DONE;
            rdata_r <= drdata;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          dreq_r   <= 1'b0;
          dwr_r    <= 1'b0;
          dwstrb_r <= 4'b0000;
        end
      endcase
    end
  end

  assign dreq   = dreq_r;
  assign dwr    = dwr_r;
  assign dwstrb = dwstrb_r;
  assign daddr  = daddr_r;
  assign dwdata = dwdata_r;

  // Writeback, stall and alignment-exception outputs. NOPs pass through in the
  // same cycle; memory ops only present a result in DONE.
  always_comb begin
    wb_waddr  = mem_waddr;
    wb_wdata  = mem_wdata;
    wb_write  = 1'b0;
    stall_req = 1'b0;
    ale       = 1'b0;
    ale_addr  = ZERO_WORD;
    if (rst == RST_ENABLE) begin
      wb_write  = 1'b0;
      stall_req = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fault_s) begin
`ifdef MEM_ALIGN_CHECK_EN
            ale      = 1'b1;
            ale_addr = mem_addr;
`endif
          end else if (op_mem_s) begin
            stall_req = 1'b1;
          end else begin
            wb_write = mem_write;
          end
        end
        ST_REQ, ST_WAIT: begin
          stall_req = 1'b1;
        end
        ST_DONE: begin
          if (op_load_s) begin
            wb_wdata = load_data_s;
            wb_write = mem_write;
          end else begin
            wb_write = 1'b0;
          end
        end
        default: begin
          stall_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Directed bench for the MEM stage. A small SRAM responder drives daddr_ok /
// ddata_ok with programmable delays; expected writeback results are queued
// when an op is issued and popped when the stage reaches DONE.
// -----------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_write;
  logic        dreq;
  logic        dwr;
  logic [3:0]  dwstrb;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        daddr_ok;
  logic        ddata_ok;
  logic [31:0] drdata;
  logic        stall_req;
  logic        ale;
  logic [31:0] ale_addr;

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_write  (wb_write),
    .dreq      (dreq),
    .dwr       (dwr),
    .dwstrb    (dwstrb),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .daddr_ok  (daddr_ok),
    .ddata_ok  (ddata_ok),
    .drdata    (drdata),
    .stall_req (stall_req),
    .ale       (ale),
    .ale_addr  (ale_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wdata;
    logic        write;
    logic        has_data;
  } exp_t;

  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  int          dreq_n;
  int          stall_n;
  int          lat_n;
  bit          done_ok;
  logic [31:0] cap_daddr;
  logic [31:0] cap_dwdata;
  logic [3:0]  cap_strb;
  logic        cap_dwr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] waddr, input logic [31:0] wdata, input logic write);
    mem_op    = op;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_waddr = waddr;
    mem_wdata = wdata;
    mem_write = write;
    daddr_ok  = 1'b0;
    ddata_ok  = 1'b0;
  endtask

  // SRAM responder: accepts the address after alat cycles of dreq, completes
  // dlat cycles later. Returns at the negedge of the first unstalled cycle.
  task automatic run_access(input string tag, input int alat, input int dlat, input logic [31:0] rdata);
    int phase;
    int cnt;
    phase = 0; cnt = 0;
    dreq_n = 0; stall_n = 0; lat_n = 0; done_ok = 1'b0;
    cap_daddr = 32'h0; cap_dwdata = 32'h0; cap_strb = 4'h0; cap_dwr = 1'b0;
    @(negedge clk);
    chk({tag, " issue stall"}, {31'd0, stall_req}, 32'd1);
    chk({tag, " issue dreq"}, {31'd0, dreq}, 32'd0);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      daddr_ok = 1'b0;
      ddata_ok = 1'b0;
      if (phase == 0 && dreq) begin
        if (cnt == alat) begin
          daddr_ok = 1'b1; phase = 1; cnt = 0;
        end else begin
          cnt++;
        end
      end else if (phase == 1) begin
        cnt++;
        if (cnt == dlat) begin
          ddata_ok = 1'b1; drdata = rdata; phase = 2;
        end
      end else if (phase == 2) begin
        drdata = ~rdata;
      end
      @(negedge clk);
      lat_n++;
      if (dreq) begin
        dreq_n++;
        cap_daddr = daddr; cap_dwdata = dwdata; cap_strb = dwstrb; cap_dwr = dwr;
      end
      if (!stall_req) begin
        done_ok = 1'b1;
        return;
      end
      stall_n++;
    end
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, " completed"}, {31'd0, done_ok}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " wb_write"}, {31'd0, wb_write}, {31'd0, e.write});
      if (e.has_data) chk({tag, " wb_wdata"}, wb_wdata, e.wdata);
      chk({tag, " wb_waddr"}, {27'd0, wb_waddr}, {27'd0, mem_waddr});
      chk({tag, " dreq low in done"}, {31'd0, dreq}, 32'd0);
      chk({tag, " dwr/dwstrb low"}, {27'd0, dwr, dwstrb}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drdata = 32'h0;
    drive_op(4'd5, 32'h0000_0010, 32'h0, 5'd1, 32'h1111_1111, 1'b1);
    #3;
    // Reset state with a load present: nothing requested, nothing stalled.
    chk("reset dreq", {31'd0, dreq}, 32'd0);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    chk("reset wb_write", {31'd0, wb_write}, 32'd0);
    chk("reset ale", {31'd0, ale}, 32'd0);
    drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // NOP passthrough, same cycle.
    @(posedge clk); #1;
    drive_op(4'd0, 32'h0, 32'h0, 5'd5, 32'h0000_1234, 1'b1);
    #1;
    chk("nop wb_waddr", {27'd0, wb_waddr}, 32'd5);
    chk("nop wb_wdata", wb_wdata, 32'h0000_1234);
    chk("nop wb_write", {31'd0, wb_write}, 32'd1);
    chk("nop dreq", {31'd0, dreq}, 32'd0);
    chk("nop stall", {31'd0, stall_req}, 32'd0);
    drive_op(4'd12, 32'h0000_0003, 32'h0, 5'd6, 32'h0000_5678, 1'b1);
    #1;
    chk("op12 wb_write", {31'd0, wb_write}, 32'd1);
    chk("op12 stall", {31'd0, stall_req}, 32'd0);

    // LB sign-extended from top lane, minimum latency.
    @(posedge clk); #1;
    drive_op(4'd1, 32'h0000_1003, 32'h0, 5'd7, 32'hDEAD_0000, 1'b1);
    sb_q.push_back('{32'hFFFF_FF80, 1'b1, 1'b1});
    run_access("lb", 0, 1, 32'h80FF_FFFF);
    chk("lb dreq cycles", dreq_n, 32'd1);
    chk("lb stall cycles", stall_n, 32'd2);
    chk("lb latency", lat_n, 32'd3);
    chk("lb daddr", cap_daddr, 32'h0000_1000);
    chk("lb dwr/strb", {27'd0, cap_dwr, cap_strb}, 32'd0);
    check_done("lb");

    // LBU lane 1.
    @(posedge clk); #1;
    drive_op(4'd2, 32'h0000_1001, 32'h0, 5'd8, 32'h0, 1'b1);
    sb_q.push_back('{32'h0000_00A5, 1'b1, 1'b1});
    run_access("lbu", 1, 2, 32'h1234_A5CC);
    check_done("lbu");

    // LH upper half, negative.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h0000_1002, 32'h0, 5'd9, 32'h0, 1'b1);
    sb_q.push_back('{32'hFFFF_8001, 1'b1, 1'b1});
    run_access("lh", 0, 1, 32'h8001_7FFF);
    check_done("lh");

    // LHU lower half, wb_write follows mem_write (0 here).
    @(posedge clk); #1;
    drive_op(4'd4, 32'h0000_1000, 32'h0, 5'd10, 32'h0, 1'b0);
    sb_q.push_back('{32'h0000_F00D, 1'b0, 1'b1});
    run_access("lhu", 0, 1, 32'h8001_F00D);
    check_done("lhu");

    // LW with slow address accept and slow completion.
    @(posedge clk); #1;
    drive_op(4'd5, 32'h0000_1004, 32'h0, 5'd11, 32'h0, 1'b1);
    sb_q.push_back('{32'hCAFE_BABE, 1'b1, 1'b1});
    run_access("lw slow", 3, 4, 32'hCAFE_BABE);
    chk("lw slow dreq cycles", dreq_n, 32'd4);
    chk("lw slow stall cycles", stall_n, 32'd8);
    check_done("lw slow");

    // SH to upper half.
    @(posedge clk); #1;
    drive_op(4'd7, 32'h0000_2002, 32'h0000_ABCD, 5'd12, 32'h0000_2002, 1'b1);
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    run_access("sh", 0, 1, 32'h0);
    chk("sh daddr", cap_daddr, 32'h0000_2000);
    chk("sh dwstrb", {28'd0, cap_strb}, 32'h0000_000C);
    chk("sh dwdata", cap_dwdata, 32'hABCD_ABCD);
    chk("sh dwr", {31'd0, cap_dwr}, 32'd1);
    check_done("sh");

    // SB lane 1.
    @(posedge clk); #1;
    drive_op(4'd6, 32'h0000_2001, 32'h1234_56EF, 5'd13, 32'h0, 1'b1);
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    run_access("sb", 2, 1, 32'h0);
    chk("sb dwstrb", {28'd0, cap_strb}, 32'h0000_0002);
    chk("sb dwdata", cap_dwdata, 32'hEFEF_EFEF);
    check_done("sb");

    // SW full word.
    @(posedge clk); #1;
    drive_op(4'd8, 32'h0000_2004, 32'h89AB_CDEF, 5'd14, 32'h0, 1'b1);
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    run_access("sw", 0, 3, 32'h0);
    chk("sw dwstrb", {28'd0, cap_strb}, 32'h0000_000F);
    chk("sw dwdata", cap_dwdata, 32'h89AB_CDEF);
    chk("sw daddr", cap_daddr, 32'h0000_2004);
    check_done("sw");

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word faults: no request, one-cycle ale.
    @(posedge clk); #1;
    drive_op(4'd5, 32'h0000_3001, 32'h0, 5'd15, 32'h0, 1'b1);
    @(negedge clk);
    chk("ale dreq", {31'd0, dreq}, 32'd0);
    chk("ale flag", {31'd0, ale}, 32'd1);
    chk("ale addr", ale_addr, 32'h0000_3001);
    chk("ale stall", {31'd0, stall_req}, 32'd0);
    chk("ale wb_write", {31'd0, wb_write}, 32'd0);
    @(posedge clk); #1;
    drive_op(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk("ale cleared", {31'd0, ale}, 32'd0);
    chk("ale no request", {31'd0, dreq}, 32'd0);
`else
    // Misaligned half: addr[0] ignored, ale stays tied off.
    @(posedge clk); #1;
    drive_op(4'd3, 32'h0000_4003, 32'h0, 5'd15, 32'h0, 1'b1);
    sb_q.push_back('{32'hFFFF_8123, 1'b1, 1'b1});
    run_access("lh misaligned", 0, 1, 32'h8123_4567);
    chk("lh misaligned daddr", cap_daddr, 32'h0000_4000);
    chk("lh misaligned ale", {31'd0, ale}, 32'd0);
    chk("lh misaligned ale_addr", ale_addr, 32'h0);
    check_done("lh misaligned");
`endif

    // Reset during WAIT, then a stray completion.
    @(posedge clk); #1;
    drive_op(4'd5, 32'h0000_5000, 32'h0, 5'd3, 32'h0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    daddr_ok = 1'b1;
    @(negedge clk);
    chk("rst-wait dreq in req", {31'd0, dreq}, 32'd1);
    @(posedge clk); #1;
    daddr_ok = 1'b0;
    @(negedge clk);
    chk("rst-wait stall in wait", {31'd0, stall_req}, 32'd1);
    #2;
    rst = 1'b0;
    drive_op(4'd0, 32'h0, 32'h0, 5'd3, 32'h0, 1'b0);
    #1;
    chk("rst-wait stall", {31'd0, stall_req}, 32'd0);
    chk("rst-wait dreq", {31'd0, dreq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    ddata_ok = 1'b1;
    drdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray ddata wb_write", {31'd0, wb_write}, 32'd0);
    chk("stray ddata stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    ddata_ok = 1'b0;
    @(negedge clk);
    chk("stray ddata no pulse", {31'd0, wb_write}, 32'd0);
    @(posedge clk); #1;
    drive_op(4'd0, 32'h0, 32'h0, 5'd9, 32'h0000_0055, 1'b1);
    #1;
    chk("post-reset idle passthrough", {31'd0, wb_write}, 32'd1);
    chk("post-reset wb_wdata", wb_wdata, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
